// File: rtl/serv_immdec.sv
// serv_immdec: captures instruction fields and shifts the sign-extended immediate out LSB first
module serv_immdec #(
  parameter int SHARED_RFADDR_IMM_REGS = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cnt_en,
  input  logic        i_cnt_done,
  input  logic [3:0]  i_immdec_en,
  input  logic        i_csr_imm_en,
  input  logic [3:0]  i_ctrl,
  input  logic        i_wb_en,
  input  logic [24:0] i_wb_rdt,
  output logic [4:0]  o_rd_addr,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic        o_csr_imm,
  output logic        o_imm
);
  logic       r_imm31;
  logic [8:0] r_imm19_12_20;
  logic       r_imm7;
  logic [5:0] r_imm30_25;
  logic [4:0] r_imm24_20;
  logic [4:0] r_imm11_7;
  logic       w_sign;
  logic       w_msb19;
  logic       w_msb30;
  always_comb begin
    w_sign  = r_imm31 & ~i_csr_imm_en;
    w_msb19 = i_ctrl[3] ? w_sign : r_imm24_20[0];
    w_msb30 = i_ctrl[2] ? r_imm7 : i_ctrl[1] ? w_sign : r_imm19_12_20[0];
  end
  // i_wb_rdt[k] is instruction bit k+7
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_imm31       <= 1'b0;
      r_imm19_12_20 <= '0;
      r_imm7        <= 1'b0;
      r_imm30_25    <= '0;
      r_imm24_20    <= '0;
      r_imm11_7     <= '0;
    end else if (i_wb_en) begin
      r_imm31       <= i_wb_rdt[24];
      r_imm19_12_20 <= {i_wb_rdt[12:5], i_wb_rdt[13]};
      r_imm7        <= i_wb_rdt[0];
      r_imm30_25    <= i_wb_rdt[23:18];
      r_imm24_20    <= i_wb_rdt[17:13];
      r_imm11_7     <= i_wb_rdt[4:0];
    end else if (i_cnt_en) begin
      r_imm7 <= w_sign;
      if (i_immdec_en[1]) r_imm19_12_20 <= {w_msb19, r_imm19_12_20[8:1]};
      if (i_immdec_en[3]) r_imm30_25    <= {w_msb30, r_imm30_25[5:1]};
      if (i_immdec_en[2]) r_imm24_20    <= {r_imm30_25[0], r_imm24_20[4:1]};
      if (i_immdec_en[0]) r_imm11_7     <= {r_imm30_25[0], r_imm11_7[4:1]};
    end
  end
  if (SHARED_RFADDR_IMM_REGS == 1) begin : g_shared
    assign o_rd_addr  = r_imm11_7;
    assign o_rs1_addr = r_imm19_12_20[8:4];
    assign o_rs2_addr = r_imm24_20;
  end else begin : g_unshared
    assign o_rd_addr  = '0;
    assign o_rs1_addr = '0;
    assign o_rs2_addr = '0;
  end
  assign o_csr_imm = r_imm19_12_20[4];
  assign o_imm     = i_cnt_done ? w_sign : (i_ctrl[0] ? r_imm11_7[0] : r_imm24_20[0]);
endmodule

// File: tb/tb_serv_immdec.sv
// tb_serv_immdec: directed and randomized checks of serv_immdec against a field-level model
module tb_serv_immdec;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnt_en;
  logic        cnt_done;
  logic [3:0]  immdec_en;
  logic        csr_imm_en;
  logic [3:0]  ctrl;
  logic        wb_en;
  logic [24:0] wb_rdt;
  logic [4:0]  rd_addr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        csr_imm;
  logic        imm;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic       b31;
    logic [8:0] b19;
    logic       b7;
    logic [5:0] b30;
    logic [4:0] b24;
    logic [4:0] b11;
  } st_t;
  st_t m;
  serv_immdec dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cnt_en(cnt_en), .i_cnt_done(cnt_done),
    .i_immdec_en(immdec_en), .i_csr_imm_en(csr_imm_en), .i_ctrl(ctrl),
    .i_wb_en(wb_en), .i_wb_rdt(wb_rdt), .o_rd_addr(rd_addr), .o_rs1_addr(rs1_addr),
    .o_rs2_addr(rs2_addr), .o_csr_imm(csr_imm), .o_imm(imm)
  );
  always #5 clk = ~clk;
  function automatic st_t fields(input logic [31:0] ins);
    fields = '{b31: ins[31], b19: {ins[19:12], ins[20]}, b7: ins[7],
               b30: ins[30:25], b24: ins[24:20], b11: ins[11:7]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    logic s;
    s = m.b31 & ~csr_imm_en;
    chk("rd", 32'(rd_addr), 32'(m.b11));
    chk("rs1", 32'(rs1_addr), 32'(m.b19[8:4]));
    chk("rs2", 32'(rs2_addr), 32'(m.b24));
    chk("csr_imm", 32'(csr_imm), 32'(m.b19[4]));
    chk("imm", 32'(imm), 32'(cnt_done ? s : ctrl[0] ? m.b11[0] : m.b24[0]));
  endtask
  task automatic clock();
    st_t o;
    logic s;
    o = m;
    s = o.b31 & ~csr_imm_en;
    if (!rst_n) m = '0;
    else if (wb_en) m = fields({wb_rdt, 7'b0});
    else if (cnt_en) begin
      m.b7 = s;
      if (immdec_en[1]) m.b19 = {ctrl[3] ? s : o.b24[0], o.b19[8:1]};
      if (immdec_en[3]) m.b30 = {ctrl[2] ? o.b7 : ctrl[1] ? s : o.b19[0], o.b30[5:1]};
      if (immdec_en[2]) m.b24 = {o.b30[0], o.b24[4:1]};
      if (immdec_en[0]) m.b11 = {o.b30[0], o.b11[4:1]};
    end
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [31:0] ins);
    wb_en = 1'b1;
    cnt_en = 1'b0;
    wb_rdt = ins[31:7];
    clock();
    wb_en = 1'b0;
  endtask
  initial begin
    logic [31:0] ins;
    logic [31:0] sext;
    m = '1;
    rst_n = 1'b0; cnt_en = 1'b1; cnt_done = 1'b0; immdec_en = 4'hf; csr_imm_en = 1'b0;
    ctrl = 4'h5; wb_en = 1'b1; wb_rdt = 25'h1ffffff;
    clock();
    clock();
    rst_n = 1'b1; wb_en = 1'b0; cnt_en = 1'b0; cnt_done = 1'b1;
    #1;
    chk("rst_rd", 32'(rd_addr), 0);
    chk("rst_rs1", 32'(rs1_addr), 0);
    chk("rst_rs2", 32'(rs2_addr), 0);
    chk("rst_csr", 32'(csr_imm), 0);
    chk("rst_imm", 32'(imm), 0);
    cnt_done = 1'b0; ctrl = 4'h0;
    load(32'h55E6F080);
    #1;
    chk("ld_rd", 32'(rd_addr), 1);
    chk("ld_rs1", 32'(rs1_addr), 13);
    chk("ld_rs2", 32'(rs2_addr), 30);
    chk("ld_csr", 32'(csr_imm), 1);
    chk("ld_imm", 32'(imm), 0);
    check_all();
    load(32'hFFF00093);
    for (int k = 0; k < 32; k++) begin
      ctrl = 4'b0010; immdec_en = 4'b1100; cnt_en = 1'b1; cnt_done = (k == 31);
      #1;
      chk("itype_imm", 32'(imm), 1);
      chk("itype_rd", 32'(rd_addr), 1);
      chk("itype_rs1", 32'(rs1_addr), 0);
      clock();
    end
    cnt_en = 1'b0; cnt_done = 1'b0;
    load(32'hFFF00093);
    csr_imm_en = 1'b1; cnt_done = 1'b1;
    #1;
    chk("csr_zext", 32'(imm), 0);
    csr_imm_en = 1'b0;
    #1;
    chk("sign_done", 32'(imm), 1);
    cnt_done = 1'b0; ctrl = 4'h0;
    load(32'h12345678);
    wb_en = 1'b1; cnt_en = 1'b1; immdec_en = 4'b1111; wb_rdt = 25'hABCDE1;
    clock();
    wb_en = 1'b0; cnt_en = 1'b0;
    #1;
    chk("prio_rd", 32'(rd_addr), 1);
    chk("prio_rs1", 32'(rs1_addr), 13);
    chk("prio_rs2", 32'(rs2_addr), 30);
    chk("prio_csr", 32'(csr_imm), 1);
    rst_n = 1'b0; wb_en = 1'b1; cnt_en = 1'b1; wb_rdt = 25'h1ffffff;
    clock();
    rst_n = 1'b1; wb_en = 1'b0; cnt_en = 1'b0; cnt_done = 1'b1;
    #1;
    chk("rstwb_rd", 32'(rd_addr), 0);
    chk("rstwb_rs1", 32'(rs1_addr), 0);
    chk("rstwb_rs2", 32'(rs2_addr), 0);
    chk("rstwb_imm", 32'(imm), 0);
    cnt_done = 1'b0;
    load(32'h55E6F080);
    immdec_en = 4'b0001; cnt_en = 1'b1;
    for (int k = 0; k < 5; k++) clock();
    cnt_en = 1'b0;
    #1;
    chk("gate_rs1", 32'(rs1_addr), 13);
    chk("gate_rs2", 32'(rs2_addr), 30);
    chk("gate_rd", 32'(rd_addr), 0);
    check_all();
    // I- and S-type immediates must come out as the 32-bit sign-extended value, LSB first
    for (int n = 0; n < 16; n++) begin
      ins = $urandom;
      sext = n[0] ? {{20{ins[31]}}, ins[31:25], ins[11:7]} : {{20{ins[31]}}, ins[31:20]};
      load(ins);
      for (int k = 0; k < 32; k++) begin
        ctrl = n[0] ? 4'b0011 : 4'b0010;
        immdec_en = n[0] ? 4'b1001 : 4'b1100;
        cnt_en = 1'b1; cnt_done = (k == 31);
        #1;
        chk(n[0] ? "stype_bit" : "itype_bit", 32'(imm), 32'(sext[k]));
        clock();
      end
      cnt_en = 1'b0; cnt_done = 1'b0;
    end
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      wb_en = ($urandom_range(0, 7) == 0);
      cnt_en = 1'($urandom);
      cnt_done = ($urandom_range(0, 7) == 0);
      immdec_en = 4'($urandom);
      csr_imm_en = ($urandom_range(0, 3) == 0);
      ctrl = 4'($urandom);
      wb_rdt = 25'($urandom);
      #1;
      check_all();
      clock();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
